hazard_ctrl_unit: RTL

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard detection and forwarding control for a classic 5-stage in-order
// pipeline (IF / ID / EX / MEM / WB).
//
// Behaviour
//   * Load-use hazard: stalls PC and IF/ID and injects a bubble into ID/EX
//     for one cycle (BUBBLE state).
//   * Taken branch resolved in EX: flushes IF/ID and ID/EX that cycle, then
//     flushes IF/ID once more in REDIRECT to cover the one-cycle fetch latency.
//   * Operand forwarding selects for the EX stage (MEM has priority over WB).
//   * Saturating event counters for stalls and branch flushes.
//
// Ports
//   clk                         clock, all state updates on rising edge
//   reset                       asynchronous active-low reset
//   id_rs1/id_rs2               source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2     ID instruction actually reads that source
//   ex_rs1/ex_rs2               source registers of the EX instruction
//   ex_rd/ex_reg_wr/ex_mem_reg  EX destination, write enable, load flag
//   mem_rd/mem_reg_wr           MEM destination and write enable
//   wb_rd/wb_reg_wr             WB destination and write enable
//   ex_branch_taken             control transfer resolved taken in EX
//   cnt_clr                     synchronous clear of both counters
//   pc_stall/ifid_stall         hold PC / IF-ID register
//   ifid_flush/idex_flush       squash IF-ID / ID-EX register contents
//   fwd_a_sel/fwd_b_sel         EX operand source: 00 regfile, 01 MEM, 10 WB
//   stall_count/flush_count     saturating event counters (CNT_W bits)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_reg,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wr,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wr,
  input  logic             ex_branch_taken,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic load_use;
  logic stall_evt;   // load-use stall fired this cycle
  logic flush_evt;   // branch flush fired this cycle
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;

  // A load in EX whose destination feeds the ID instruction cannot be
  // forwarded in time; x0 is never a real dependency.
  assign load_use = ex_mem_reg & ex_reg_wr & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Forwarding select for one EX operand: the younger producer (MEM) wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end
    if (wb_reg_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  // Saturating counter step; a clear beats a same-cycle increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic             inc,
                                                 input logic             clr);
    if (clr) begin
      return '0;
    end
    if (inc && (cur != '1)) begin
      return cur + CNT_W'(1);
    end
    return cur;
  endfunction

  // Next-state and Mealy control outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // Branch wins: the stalled ID instruction is on the wrong path anyway.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_evt    = 1'b1;
          state_d      = REDIRECT;
        end else if (load_use) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          stall_evt    = 1'b1;
          state_d      = BUBBLE;
        end
      end
      BUBBLE: begin
        // The bubble instruction now in EX cannot create a new load-use, but
        // the instruction ahead of it can still resolve a taken branch.
        if (ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_evt    = 1'b1;
          state_d      = REDIRECT;
        end else begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        // The fetch issued in the branch cycle still came from the old PC.
        ifid_flush_c = 1'b1;
        state_d      = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_count_d = cnt_next(stall_count_q, stall_evt, cnt_clr);
    flush_count_d = cnt_next(flush_count_q, flush_evt, cnt_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering. Reset is
  // asynchronous so the pipeline is quiesced without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Control outputs are combinational, so they are gated by reset directly:
  // a taken branch or hazard pattern on the inputs must not leak out while
  // the pipeline is being reset.
  always_comb begin
    pc_stall   = reset & pc_stall_c;
    ifid_stall = reset & ifid_stall_c;
    ifid_flush = reset & ifid_flush_c;
    idex_flush = reset & idex_flush_c;
    fwd_a_sel  = reset ? fwd_sel(ex_rs1) : FWD_RF;
    fwd_b_sel  = reset ? fwd_sel(ex_rs2) : FWD_RF;
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
